// File: rtl/r_clk_module_if.sv
// ---------------------------------------------------------------------------
// r_clk_module_if
//   Read-side bundle of the asynchronous FIFO: the consumer read request,
//   the write pointer coming in from the write clock domain, and the read
//   pointer, RAM address and status flags produced by the read controller.
//
//   master : consumer / write-domain side (drives r_en, w_ptr)
//   slave  : read-side controller r_clk_module
//
//   r_en            read request
//   w_ptr           Gray write pointer, write-clock launched (MEMORY_DEPTH+1)
//   r_ptr           registered Gray read pointer (MEMORY_DEPTH+1)
//   r_addr          RAM read address (MEMORY_DEPTH)
//   r_empty         registered empty flag
//   r_almost_empty  registered almost-empty flag
//   r_level         registered occupancy (MEMORY_DEPTH+1)
// ---------------------------------------------------------------------------
interface r_clk_module_if #(
  parameter int MEMORY_DEPTH = 4
);
  logic                    r_en;
  logic [MEMORY_DEPTH:0]   w_ptr;
  logic [MEMORY_DEPTH:0]   r_ptr;
  logic [MEMORY_DEPTH-1:0] r_addr;
  logic                    r_empty;
  logic                    r_almost_empty;
  logic [MEMORY_DEPTH:0]   r_level;

  modport master (
    output r_en,
    output w_ptr,
    input  r_ptr,
    input  r_addr,
    input  r_empty,
    input  r_almost_empty,
    input  r_level
  );

  modport slave (
    input  r_en,
    input  w_ptr,
    output r_ptr,
    output r_addr,
    output r_empty,
    output r_almost_empty,
    output r_level
  );
endinterface

// File: rtl/r_clk_module.sv
// ---------------------------------------------------------------------------
// r_clk_module
//   Read-side pointer and empty-flag controller of an asynchronous FIFO.
//   Keeps the read pointer in binary and Gray form, drives the RAM read
//   address, brings the write-domain Gray pointer across with a two-flop
//   synchronizer and produces registered empty / almost-empty / occupancy.
//
//   Ports:
//     r_clk   read clock (only clock of the block)
//     r_rst   synchronous, active-high reset
//     bus     r_clk_module_if.slave (r_en, w_ptr in; r_ptr, r_addr,
//             r_empty, r_almost_empty, r_level out)
//
//   Status is pessimistic: the write pointer is seen 2-3 read cycles late,
//   so empty may linger after a write but never clears on a truly empty
//   FIFO. The controller's own reads are reflected immediately because the
//   flags are computed from the next read pointer.
// ---------------------------------------------------------------------------
module r_clk_module #(
  parameter int MEMORY_DEPTH        = 4,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input logic           r_clk,
  input logic           r_rst,
  r_clk_module_if.slave bus
);

  localparam int PW = MEMORY_DEPTH + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] rq1_wptr;
  logic [PW-1:0] rq2_wptr;
  logic          r_empty;
  logic          r_almost_empty;
  logic [PW-1:0] r_level;

  logic          accepted;
  logic [PW-1:0] r_bnext;
  logic [PW-1:0] r_gnext;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] occ_next;

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  always_comb begin
    // Reads against an empty FIFO are dropped; the pointer simply holds.
    accepted = bus.r_en & ~r_empty;
    r_bnext  = rbin + PW'(accepted);
    r_gnext  = r_bnext ^ (r_bnext >> 1);
    wq_bin   = gray2bin(rq2_wptr);
    // Modulo subtraction: an MSB difference with equal low bits reads as a
    // full FIFO (2^MEMORY_DEPTH), never as empty.
    occ_next = wq_bin - r_bnext;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain rq1_wptr straight into
  // rq2_wptr and collapse the synchronizer to a single stage.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      rbin           <= '0;
      r_ptr          <= '0;
      rq1_wptr       <= '0;
      rq2_wptr       <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
    end else begin
      rbin           <= r_bnext;
      r_ptr          <= r_gnext;
      // No logic ahead of the first stage: only a single Gray-coded bus
      // crosses the clock boundary.
      rq1_wptr       <= bus.w_ptr;
      rq2_wptr       <= rq1_wptr;
      r_empty        <= (r_gnext == rq2_wptr);
      r_almost_empty <= (occ_next <= AE_THRESH);
      r_level        <= occ_next;
    end
  end

  // Same Gray-derived mapping as the write side, so one pointer value
  // addresses the same RAM word on both ports.
  assign bus.r_addr = {r_ptr[MEMORY_DEPTH] ^ r_ptr[MEMORY_DEPTH-1],
                       r_ptr[MEMORY_DEPTH-2:0]};

  assign bus.r_ptr          = r_ptr;
  assign bus.r_empty        = r_empty;
  assign bus.r_almost_empty = r_almost_empty;
  assign bus.r_level        = r_level;

endmodule

// File: tb/tb_r_clk_module.sv
// ---------------------------------------------------------------------------
// tb_r_clk_module
//   Directed bench for r_clk_module (MEMORY_DEPTH = 4, threshold = 2).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_r_clk_module;

  localparam int MD = 4;

  logic r_clk = 1'b0;
  logic r_rst;

  int tests = 0;
  int fails = 0;

  r_clk_module_if #(.MEMORY_DEPTH(MD)) bus ();

  r_clk_module #(
    .MEMORY_DEPTH        (MD),
    .ALMOST_EMPTY_THRESH (2)
  ) dut (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .bus   (bus)
  );

  always #5 r_clk = ~r_clk;

  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [4:0] gray(input int b);
    logic [4:0] bb;
    bb = 5'(b);
    return bb ^ (bb >> 1);
  endfunction

  function automatic logic [3:0] addr_of(input int b);
    logic [4:0] g;
    g = gray(b);
    return {g[4] ^ g[3], g[2:0]};
  endfunction

  initial begin
    int  wbin;
    int  rcount;
    bit  acc;
    bit  saw_top;

    // ---------------- reset ----------------
    r_rst     = 1'b1;
    bus.r_en  = 1'b0;
    bus.w_ptr = '0;
    step();
    step();
    check("rst_r_ptr",   32'(bus.r_ptr), 0);
    check("rst_r_addr",  32'(bus.r_addr), 0);
    check("rst_empty",   32'(bus.r_empty), 1);
    check("rst_aempty",  32'(bus.r_almost_empty), 1);
    check("rst_level",   32'(bus.r_level), 0);

    // ---------------- fill to 3, then drain ----------------
    r_rst     = 1'b0;
    bus.w_ptr = 5'b00010;            // Gray of binary 3
    step();
    check("fill_empty_e1", 32'(bus.r_empty), 1);
    step();
    check("fill_empty_e2", 32'(bus.r_empty), 1);
    step();
    check("fill_empty_e3", 32'(bus.r_empty), 0);
    check("fill_level",    32'(bus.r_level), 3);
    check("fill_aempty",   32'(bus.r_almost_empty), 0);
    check("drain_addr0",   32'(bus.r_addr), 0);

    bus.r_en = 1'b1;
    step();
    check("drain_addr1",   32'(bus.r_addr), 1);
    check("drain_level2",  32'(bus.r_level), 2);
    check("drain_ae2",     32'(bus.r_almost_empty), 1);
    check("drain_empty2",  32'(bus.r_empty), 0);
    step();
    check("drain_addr3",   32'(bus.r_addr), 3);
    check("drain_level1",  32'(bus.r_level), 1);
    check("drain_empty1",  32'(bus.r_empty), 0);
    step();
    check("drain_empty0",  32'(bus.r_empty), 1);
    check("drain_level0",  32'(bus.r_level), 0);
    check("drain_r_ptr",   32'(bus.r_ptr), 32'h02);
    check("drain_addr_end", 32'(bus.r_addr), 2);

    // ---------------- underflow ----------------
    for (int i = 0; i < 5; i++) begin
      step();
      check("uflow_r_ptr", 32'(bus.r_ptr), 32'h02);
      check("uflow_empty", 32'(bus.r_empty), 1);
    end

    // ---------------- streaming wrap-around ----------------
    r_rst     = 1'b1;
    bus.r_en  = 1'b0;
    bus.w_ptr = '0;
    step();
    r_rst    = 1'b0;
    bus.r_en = 1'b1;
    wbin     = 0;
    rcount   = 0;
    saw_top  = 1'b0;
    for (int cyc = 0; cyc < 300 && rcount < 40; cyc++) begin
      // Non-empty must imply real data; reported level never exceeds truth.
      check("stream_empty_sound",
            32'(bus.r_empty || (wbin - rcount) > 0), 1);
      check("stream_level_sound",
            32'(int'(bus.r_level) <= (wbin - rcount)), 1);
      acc = bus.r_en && !bus.r_empty;
      step();
      if (acc) rcount++;
      if (wbin < 40) wbin++;
      bus.w_ptr = gray(wbin);
      check("stream_r_ptr",  32'(bus.r_ptr), 32'(gray(rcount)));
      check("stream_r_addr", 32'(bus.r_addr), 32'(addr_of(rcount)));
      if (bus.r_ptr == 5'b11000) saw_top = 1'b1;
    end
    check("stream_count",    rcount, 40);
    check("stream_saw_16",   32'(saw_top), 1);
    check("stream_end_ptr",  32'(bus.r_ptr), 32'h0C);
    check("stream_end_empty", 32'(bus.r_empty), 1);

    // ---------------- full FIFO ----------------
    r_rst     = 1'b1;
    bus.r_en  = 1'b0;
    bus.w_ptr = '0;
    step();
    r_rst     = 1'b0;
    bus.w_ptr = 5'b11000;            // Gray of binary 16
    step();
    step();
    step();
    check("full_level",  32'(bus.r_level), 16);
    check("full_empty",  32'(bus.r_empty), 0);
    check("full_aempty", 32'(bus.r_almost_empty), 0);
    check("full_r_ptr",  32'(bus.r_ptr), 0);

    // ---------------- mid-operation reset ----------------
    bus.r_en = 1'b1;
    step();
    step();
    step();
    check("mid_r_ptr_pre", 32'(bus.r_ptr), 32'(gray(3)));
    check("mid_level_pre", 32'(bus.r_level), 13);
    r_rst = 1'b1;
    step();
    check("mid_rst_r_ptr",  32'(bus.r_ptr), 0);
    check("mid_rst_addr",   32'(bus.r_addr), 0);
    check("mid_rst_empty",  32'(bus.r_empty), 1);
    check("mid_rst_level",  32'(bus.r_level), 0);
    check("mid_rst_aempty", 32'(bus.r_almost_empty), 1);
    r_rst = 1'b0;
    step();
    check("mid_sync_e1", 32'(bus.r_empty), 1);
    step();
    check("mid_sync_e2", 32'(bus.r_empty), 1);
    step();
    check("mid_sync_e3",   32'(bus.r_empty), 0);
    check("mid_level_e3",  32'(bus.r_level), 16);
    check("mid_r_ptr_e3",  32'(bus.r_ptr), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/r_clk_module.md
# r_clk_module

Read-side pointer and empty-flag controller of the asynchronous FIFO, the counterpart of the write-side controller in the write clock domain. It owns the read pointer in both binary and Gray form and drives the RAM read address. It synchronizes the write-domain Gray pointer into the read clock domain and generates the registered `r_empty`, `r_almost_empty` and occupancy outputs. It sits between the dual-port FIFO RAM read port and the FIFO consumer.

## Interface
- `MEMORY_DEPTH`, default 4: address width in bits. The FIFO holds 2^MEMORY_DEPTH entries, and pointers are MEMORY_DEPTH+1 bits wide. Must be ≥ 2.
- `ALMOST_EMPTY_THRESH`, default 2: `r_almost_empty` asserts when occupancy ≤ this value. Legal range 0 .. 2^MEMORY_DEPTH.
- `r_clk`  in  1: read clock. This is the only clock of the block.
- `r_rst`  in  1: synchronous, active-high reset, sampled on the rising edge of `r_clk`.
- `r_en`  in  1: read request from the consumer.
- `w_ptr`  in  MEMORY_DEPTH+1: write pointer in Gray code, launched from the write clock domain.
- `r_ptr`  out  MEMORY_DEPTH+1: registered Gray read pointer, sent to the write domain.
- `r_addr`  out  MEMORY_DEPTH: RAM read address.
- `r_empty`  out  1: registered empty flag.
- `r_almost_empty`  out  1: registered almost-empty flag.
- `r_level`  out  MEMORY_DEPTH+1: registered occupancy as seen from the read domain, range 0 .. 2^MEMORY_DEPTH.

## Operation
- **State registers:**
  - `rbin`: binary read pointer, MEMORY_DEPTH+1 bits.
  - `r_ptr`: Gray read pointer.
  - `rq1_wptr`, `rq2_wptr`: two-flop synchronizer for `w_ptr`.
  - `r_empty`, `r_almost_empty`, `r_level`.
- **Read qualification and pointer update:**
  - A read is accepted when `r_en & !r_empty`.
  - `r_bnext = rbin + accepted`, computed modulo 2^(MEMORY_DEPTH+1), so it wraps naturally.
  - `r_gnext = r_bnext ^ (r_bnext >> 1)`.
  - On each edge: `rbin <= r_bnext` and `r_ptr <= r_gnext`.
- **Read address:** `r_addr = {r_ptr[MEMORY_DEPTH] ^ r_ptr[MEMORY_DEPTH-1], r_ptr[MEMORY_DEPTH-2:0]}`.
  - This is the same Gray-derived address mapping the write side uses, so a given pointer value selects the same RAM location on both ports.
  - `r_addr` is purely combinational from the `r_ptr` register.
- **Synchronizer:** `rq1_wptr <= w_ptr` and `rq2_wptr <= rq1_wptr`. No logic sits between `w_ptr` and `rq1_wptr`.
- **Empty:** `r_empty <= (r_gnext == rq2_wptr)`. The comparison is on the full MEMORY_DEPTH+1 bits, MSB included.
- **Occupancy:**
  - `wq_bin` is the Gray-to-binary conversion of `rq2_wptr`.
  - `r_level <= wq_bin - r_bnext`, modulo 2^(MEMORY_DEPTH+1).
  - `r_almost_empty <= (wq_bin - r_bnext) <= ALMOST_EMPTY_THRESH`.
- **Underflow:** `r_en` while `r_empty` is ignored. All pointers hold, and no error flag is raised.
- **Pessimism:**
  - `r_empty` and `r_level` are conservative, because the write pointer arrives late.
  - Empty may be reported while data is already present. Non-empty is never reported while the FIFO is truly empty.
- **Reset:** on `r_rst`, all registers clear at the next edge, including in the middle of a transfer; any pending read is discarded. Resulting output values:
  - `rbin`, `r_ptr`, `rq1_wptr`, `rq2_wptr`: 0
  - `r_addr`: 0
  - `r_empty`: 1
  - `r_almost_empty`: 1
  - `r_level`: 0
- **Reset coordination:** the write domain is reset independently. System-level FIFO coherency requires both sides to be reset together.

## Timing
- **Read accept:** `r_en` is sampled at a rising edge while `r_empty` = 0.
  - `r_ptr` and `r_addr` advance at that same edge.
  - RAM data for the entry is addressed by `r_addr` during the cycle in which `r_en` is asserted.
- **Write visibility:** a `w_ptr` change that is stable before edge k appears in `rq2_wptr` after edge k+1. `r_empty`, `r_level` and `r_almost_empty` update at edge k+2, i.e. 2–3 `r_clk` cycles after the write.
- **Read visibility:** the flags reflect the block's own read at the same edge that accepts it, because they are computed from `r_bnext`.
- **Simultaneous read and write:** a read of the last entry coincident with a new synchronized write pointer gives `r_empty` = 0 and `r_level` = 1 at that edge.
- **Back-to-back reads:** one read per cycle is sustained until empty. `r_empty` rises at the edge that accepts the last entry.

## Test plan
- **Reset:** assert `r_rst` for 2 cycles with `w_ptr` = 0 → all outputs at reset values; `r_empty` = 1, `r_almost_empty` = 1, `r_level` = 0, `r_addr` = 0.
- **Fill, then drain:** MEMORY_DEPTH = 4.
  - Drive `w_ptr` = 5'b00010 (binary 3) → `r_empty` falls 2 cycles later, `r_level` = 3, `r_almost_empty` = 0 (threshold 2).
  - Hold `r_en` = 1 → `r_addr` steps 0, 1, 3 in Gray order. `r_level` goes 3 → 2 → 1 → 0, and `r_almost_empty` rises at level 2. `r_empty` rises at the third accept edge.
- **Underflow:** with `r_empty` = 1, hold `r_en` = 1 for 5 cycles → `r_ptr` is unchanged and `r_empty` stays 1.
- **Wrap-around:** write and read 40 entries in a streaming pattern → `r_ptr` passes Gray 5'b11000 (binary 16) and wraps to 0. `r_addr` repeats the 16-entry sequence, and `r_empty` never falsely deasserts.
- **Full FIFO:** drive `w_ptr` = Gray of binary 16 with `rbin` = 0 → `r_level` = 16, `r_empty` = 0 (MSB difference means full, not empty).
- **Mid-operation reset:** assert `r_rst` during streaming reads with `r_en` = 1 → next edge shows `r_ptr` = 0, `r_empty` = 1, and synchronizer cleared. Non-empty reappears 2 cycles after reset release if `w_ptr` is nonzero.
